// File: rtl/toggle_rx_pkg.sv
// Shared FSM encoding, pending-counter width and default parameters for toggle_rx.
// No logic here; imported by the receiver top level.
package toggle_rx_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int PEND_W          = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_PEND_MAX    = 15;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for one asynchronous bit; latency STAGES clk edges.
// No flow control: the level is sampled every cycle.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/toggle_rx.sv
// Toggle-encoded event receiver: pulse/count/pending queue, pulse SYNC_STAGES+1 edges after first sample.
// Consumer pops with evt_valid&evt_ready; pending saturates at PEND_MAX and sets sticky ovf.
module toggle_rx
  import toggle_rx_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int PEND_MAX    = DEF_PEND_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tgl_in,
  input  logic              en,
  input  logic              clr,
  input  logic              evt_ready,
  output logic              evt_pulse,
  output logic              evt_valid,
  output logic [CNT_W-1:0]  evt_count,
  output logic [PEND_W-1:0] pend,
  output logic              ovf,
  output logic              lvl
);

  localparam logic [2:0]        INIT_LAST = 3'(SYNC_STAGES);
  localparam logic [PEND_W-1:0] PMAX      = PEND_W'(PEND_MAX);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_init_cnt;
  logic              w_lvl;
  logic              r_prev;
  logic              r_evt;
  logic              r_pulse;
  logic              r_valid;
  logic [CNT_W-1:0]  r_cnt;
  logic [PEND_W-1:0] r_pend;
  logic [PEND_W-1:0] w_pend_nxt;
  logic              r_ovf;
  logic              w_ovf_set;
  logic              w_pop;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (tgl_in),
    .q   (w_lvl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_init_cnt <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT && r_init_cnt != INIT_LAST) begin
        r_init_cnt <= r_init_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_init_cnt == INIT_LAST) w_state_nxt = en ? ST_RUN : ST_HOLD;
      ST_RUN:  if (!en) w_state_nxt = ST_HOLD;
      ST_HOLD: if (en)  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Baseline follows the synchronized level in every state, so edges seen in
  // INIT/HOLD are absorbed silently and only RUN turns a difference into an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev  <= 1'b0;
      r_evt   <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_prev  <= w_lvl;
      r_evt   <= (r_state == ST_RUN) && (w_lvl != r_prev);
      r_pulse <= r_evt;
    end
  end

  assign w_pop = r_valid && evt_ready;

  always_comb begin
    w_pend_nxt = r_pend;
    w_ovf_set  = 1'b0;
    if (clr) begin
      w_pend_nxt = '0;
    end else if (r_evt && !w_pop) begin
      if (r_pend == PMAX) begin
        w_ovf_set = 1'b1;
      end else begin
        w_pend_nxt = r_pend + PEND_W'(1);
      end
    end else if (!r_evt && w_pop) begin
      w_pend_nxt = r_pend - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend  <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_pend  <= w_pend_nxt;
      r_valid <= (w_pend_nxt != '0);
      if (clr) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (r_evt) r_cnt <= r_cnt + CNT_W'(1);
        r_ovf <= r_ovf | w_ovf_set;
      end
    end
  end

  assign evt_pulse = r_pulse;
  assign evt_valid = r_valid;
  assign evt_count = r_cnt;
  assign pend      = r_pend;
  assign ovf       = r_ovf;
  assign lvl       = w_lvl;

endmodule

// File: doc/toggle_rx.md
TOGGLE_RX -- requirements
Module: toggle_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on tgl_in (legal 2..4).
REQ-002 Parameter CNT_W, default 8, width of the event counter.
REQ-003 Parameter PEND_MAX, default 15, maximum number of unacknowledged events held.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 tgl_in  input  1  toggle-encoded event level from the T flip-flop q output; asynchronous to clk; each level change is one event.
REQ-007 en  input  1  event acceptance enable; synchronous.
REQ-008 clr  input  1  synchronous clear of evt_count, pend and ovf.
REQ-009 evt_ready  input  1  consumer accepts one pending event.
REQ-010 evt_pulse  output  1  one-cycle strobe per accepted event.
REQ-011 evt_valid  output  1  high while pend is nonzero.
REQ-012 evt_count  output  CNT_W  accepted events, modulo 2^CNT_W.
REQ-013 pend  output  4  unacknowledged events.
REQ-014 ovf  output  1  sticky overflow flag.
REQ-015 lvl  output  1  synchronized tgl_in level.

Function
REQ-016 The FSM SHALL have states INIT, RUN and HOLD.
REQ-017 INIT SHALL last exactly SYNC_STAGES cycles after reset release; on exit it latches lvl as the baseline with no event and enters RUN if en=1, otherwise HOLD.
REQ-018 RUN→HOLD when en=0; HOLD→RUN when en=1; each transition takes effect on the next edge.
REQ-019 In HOLD, edges SHALL update the baseline but SHALL NOT produce events.
REQ-020 An event SHALL be detected in RUN when lvl differs from the registered previous lvl.
REQ-021 evt_pulse SHALL assert for exactly one cycle, SYNC_STAGES+1 rising edges after the first edge that samples the new tgl_in level.
REQ-022 Each event SHALL increment evt_count in the evt_pulse cycle; 2^CNT_W-1 wraps to 0.
REQ-023 A pop SHALL occur when evt_valid=1 and evt_ready=1 in the same cycle.
REQ-024 Event only: pend+1. Pop only: pend-1. Event and pop together: pend unchanged.
REQ-025 Event with pend=PEND_MAX and no pop: pend stays PEND_MAX, ovf set, evt_count still increments, evt_pulse still asserts.
REQ-026 evt_ready with pend=0 SHALL have no effect.
REQ-027 ovf SHALL stay set until clr or rst.
REQ-028 clr=1 SHALL zero evt_count, pend and ovf on the next edge, takes priority over a coincident event or pop, and SHALL NOT change FSM state or baseline.
REQ-029 Toggles closer together than one clk period are not required to be resolved; each resolved level change counts once.

Reset
REQ-030 rst SHALL asynchronously force: state INIT, synchronizer flops and baseline 0, evt_pulse 0, evt_valid 0, evt_count 0, pend 0, ovf 0, lvl 0.
REQ-031 Reset asserted mid-operation SHALL discard pending events, and no evt_pulse SHALL be produced for any tgl_in level present at reset release.

Structure
REQ-032 Package toggle_rx_pkg SHALL hold the FSM state encodings, PEND_W (4), and default parameter values.
REQ-033 The synchronizer SHALL be a separate sub-module sync_chain (parameter STAGES, ports clk, rst, d, q); it is the only logic that samples tgl_in.
REQ-034 All outputs SHALL be driven from registers.

Verification
REQ-035 Reset release with tgl_in=1 and en=1 -> no evt_pulse within 10 cycles; evt_count=0; lvl=1.
REQ-036 Toggle tgl_in 3 times, 4 cycles apart, evt_ready=1 -> three single-cycle evt_pulses, each 3 edges after its toggle; evt_count=3; pend never exceeds 1.
REQ-037 evt_ready=0; 16 toggles -> pend=15; ovf=1; evt_count=16; then 15 cycles with evt_ready=1 -> pend=0, evt_valid=0, ovf still 1.
REQ-038 en=0; 2 toggles; then en=1; 1 toggle -> evt_count=1; no evt_pulse during HOLD.
REQ-039 Event and pop in the same cycle with pend=2 -> pend=2; clr asserted with an event in that cycle -> pend=0, evt_count=0, ovf=0.
REQ-040 evt_count=255 (CNT_W=8), one more toggle -> evt_count=0; rst asserted mid-stream -> all outputs 0 asynchronously, before the next clk edge.
